// File: rtl/stopwatch_btn_ctrl_pkg.sv
// Shared state encodings, default timing parameters and the next-state function
// for the stopwatch button controller.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int unsigned DEF_LONG_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W       = 27;

  // A long start press overrides everything; the unused code 3 falls back to IDLE.
  function automatic logic [1:0] next_state(input logic [1:0] cur,
                                            input logic       s_short,
                                            input logic       s_long);
    if (s_long) return ST_IDLE;
    case (cur)
      ST_IDLE:  return s_short ? ST_RUN   : ST_IDLE;
      ST_RUN:   return s_short ? ST_PAUSE : ST_RUN;
      ST_PAUSE: return s_short ? ST_RUN   : ST_PAUSE;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Button-level inputs and counter/display controls between debouncers,
// the controller and the BCD datapath.
interface stopwatch_btn_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       count_en;
  logic       clear;
  logic       freeze;
  logic [1:0] state;
  logic       long_led;

  modport master (output btn_start, btn_lap,
                  input  count_en, clear, freeze, state, long_led);
  modport slave  (input  btn_start, btn_lap,
                  output count_en, clear, freeze, state, long_led);
endinterface

// File: rtl/stopwatch_btn_ctrl_press_classifier.sv
// Classifies one debounced button press as short or long by counting
// consecutive high samples; pulses are registered, one cycle wide.
module press_classifier
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic short_pulse,
  output logic long_pulse,
  output logic held_long
);

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else if (btn) begin
      short_pulse <= 1'b0;
      // Saturation keeps the long pulse to a single cycle per press.
      if (cnt != LONG_C) cnt <= cnt + CNT_W'(1);
      long_pulse <= (cnt == LONG_C - CNT_W'(1));
    end else begin
      short_pulse <= (cnt != '0) && (cnt != LONG_C);
      long_pulse  <= 1'b0;
      cnt         <= '0;
    end
  end

  // Saturated count implies the latest sample was high.
  assign held_long = (cnt == LONG_C);

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch control front-end: start/lap press classifiers feeding a Moore FSM
// that drives counter enable, clear and lap display freeze.
module stopwatch_btn_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_btn_ctrl_if.slave io
);

  logic s_short, s_long, s_held;
  logic l_short, l_long, l_held;
  logic unused_lap;

  press_classifier #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_start (
    .clk(clk), .rst(rst), .btn(io.btn_start),
    .short_pulse(s_short), .long_pulse(s_long), .held_long(s_held)
  );

  press_classifier #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_lap (
    .clk(clk), .rst(rst), .btn(io.btn_lap),
    .short_pulse(l_short), .long_pulse(l_long), .held_long(l_held)
  );

  // Long lap presses carry no meaning.
  assign unused_lap = l_long | l_held;

  logic [1:0] state_q, nxt;
  logic       count_en_q, clear_q, freeze_q;

  assign nxt = next_state(state_q, s_short, s_long);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_en_q <= 1'b0;
      clear_q    <= 1'b1;
      freeze_q   <= 1'b0;
    end else begin
      state_q    <= nxt;
      count_en_q <= (nxt == ST_RUN);
      clear_q    <= (nxt == ST_IDLE);
      // Lap acts on the pre-transition state; entering IDLE always unfreezes.
      if (nxt == ST_IDLE)
        freeze_q <= 1'b0;
      else if (l_short && state_q == ST_RUN)
        freeze_q <= ~freeze_q;
      else if (l_short && state_q == ST_PAUSE)
        freeze_q <= 1'b0;
    end
  end

  assign io.state    = state_q;
  assign io.count_en = count_en_q;
  assign io.clear    = clear_q;
  assign io.freeze   = freeze_q;
  assign io.long_led = s_held;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed bench for stopwatch_btn_ctrl with LONG_CYCLES=16; expected values
// are hand-derived from the press/state sequences below.
module tb_stopwatch_btn_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_ss = 0, n_sl = 0, n_ls = 0;

  always #5 clk = ~clk;

  stopwatch_btn_ctrl_if sw_if ();

  stopwatch_btn_ctrl #(.LONG_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .io(sw_if.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; observe 1 time unit later and tally classifier pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dut.s_short) n_ss++;
    if (dut.s_long)  n_sl++;
    if (dut.l_short) n_ls++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_press(input int n);
    sw_if.btn_start = 1'b1;
    ticks(n);
    sw_if.btn_start = 1'b0;
    ticks(2);
  endtask

  task automatic lap_press(input int n);
    sw_if.btn_lap = 1'b1;
    ticks(n);
    sw_if.btn_lap = 1'b0;
    ticks(2);
  endtask

  initial begin
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    ticks(2);
    chk("rst_state",    sw_if.state,    0);
    chk("rst_count_en", sw_if.count_en, 0);
    chk("rst_clear",    sw_if.clear,    1);
    chk("rst_freeze",   sw_if.freeze,   0);
    chk("rst_long_led", sw_if.long_led, 0);
    rst = 1'b0;
    tick();

    // Short press of 5: pulse right after release edge, state one edge later.
    sw_if.btn_start = 1'b1;
    ticks(5);
    sw_if.btn_start = 1'b0;
    tick();
    chk("t1_short_pulse", dut.s_short,   1);
    chk("t1_state_hold",  sw_if.state,   0);
    tick();
    chk("t1_state",       sw_if.state,   1);
    chk("t1_count_en",    sw_if.count_en, 1);
    chk("t1_clear",       sw_if.clear,   0);
    chk("t1_pulse_gone",  dut.s_short,   0);
    chk("t1_n_short",     n_ss,          1);

    // 15 highs is still short: RUN -> PAUSE.
    start_press(15);
    chk("t2_state_pause", sw_if.state,    2);
    chk("t2_count_en",    sw_if.count_en, 0);

    // 16 highs: long at 16th edge, back to IDLE, led until release.
    n_ss = 0; n_sl = 0;
    sw_if.btn_start = 1'b1;
    ticks(15);
    chk("t2_no_long_15", dut.s_long, 0);
    tick();
    chk("t2_long_pulse", dut.s_long,     1);
    chk("t2_led_16",     sw_if.long_led, 1);
    chk("t2_state_16",   sw_if.state,    2);
    tick();
    chk("t2_state_idle", sw_if.state,    0);
    chk("t2_clear",      sw_if.clear,    1);
    chk("t2_long_once",  dut.s_long,     0);
    ticks(4);
    chk("t2_led_held",   sw_if.long_led, 1);
    sw_if.btn_start = 1'b0;
    tick();
    chk("t2_led_off",    sw_if.long_led, 0);
    tick();
    chk("t2_n_short_rel", n_ss, 0);
    chk("t2_n_long",      n_sl, 1);

    // Lap behaviour in RUN and PAUSE.
    start_press(3);
    chk("t3_state_run", sw_if.state, 1);
    lap_press(3);
    chk("t3_freeze_on",  sw_if.freeze, 1);
    lap_press(4);
    chk("t3_freeze_off", sw_if.freeze, 0);
    n_ls = 0;
    lap_press(40);
    chk("t3_lap_long_ign", sw_if.freeze, 0);
    chk("t3_lap_no_short", n_ls, 0);
    lap_press(2);
    chk("t3_freeze_on2", sw_if.freeze, 1);
    start_press(2);
    chk("t3_pause",        sw_if.state,  2);
    chk("t3_pause_frozen", sw_if.freeze, 1);
    lap_press(2);
    chk("t3_pause_unfreeze", sw_if.freeze, 0);
    chk("t3_pause_state",    sw_if.state,  2);

    // Start long coincident with lap short while frozen in RUN.
    start_press(2);
    lap_press(2);
    chk("t4_run",    sw_if.state,  1);
    chk("t4_frozen", sw_if.freeze, 1);
    sw_if.btn_start = 1'b1;
    ticks(12);
    sw_if.btn_lap = 1'b1;
    ticks(3);
    sw_if.btn_lap = 1'b0;
    tick();
    chk("t4_both_long",  dut.s_long,  1);
    chk("t4_both_short", dut.l_short, 1);
    tick();
    chk("t4_state",  sw_if.state,  0);
    chk("t4_freeze", sw_if.freeze, 0);
    chk("t4_clear",  sw_if.clear,  1);
    sw_if.btn_start = 1'b0;
    ticks(2);

    // Reset in the middle of a held press: only post-reset samples count.
    n_ss = 0; n_sl = 0;
    sw_if.btn_start = 1'b1;
    ticks(10);
    rst = 1'b1;
    ticks(3);
    chk("t5_rst_state", sw_if.state, 0);
    rst = 1'b0;
    ticks(10);
    sw_if.btn_start = 1'b0;
    tick();
    chk("t5_short_pulse", dut.s_short, 1);
    tick();
    chk("t5_state",  sw_if.state, 1);
    chk("t5_n_long", n_sl, 0);

    // Illegal state code recovers to IDLE on the next edge.
    @(negedge clk);
    force dut.state_q = 2'd3;
    #1;
    release dut.state_q;
    tick();
    chk("t6_state",    sw_if.state,    0);
    chk("t6_clear",    sw_if.clear,    1);
    chk("t6_count_en", sw_if.count_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
